pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 30 +++
 rtl/pc_sequencer.sv | 93 +++++++++
 tb/tb_pc_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions: sequencer state encoding, default PC stride and the
// 32-bit instruction layout {opcode, arg1, arg2, result}.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_t;

  localparam int PC_STEP = 4;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 24;
  localparam int ARG1_MSB   = 23;
  localparam int ARG1_LSB   = 16;
  localparam int ARG2_MSB   = 15;
  localparam int ARG2_LSB   = 8;
  localparam int RESULT_MSB = 7;
  localparam int RESULT_LSB = 0;

  typedef struct packed {
    logic [OPCODE_MSB-OPCODE_LSB:0] opcode;
    logic [ARG1_MSB-ARG1_LSB:0]     arg1;
    logic [ARG2_MSB-ARG2_LSB:0]     arg2;
    logic [RESULT_MSB-RESULT_LSB:0] result;
  } instr_t;

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction at a time, holds it for
// decode until exec_done, then steps, jumps or halts.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                PC_STEP  = pc_sequencer_pkg::PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_data,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              is_cond,
  input  logic              take,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output seq_state_t        dbg_state
);

  // Handshakes: imem_data is captured on any FETCH cycle with imem_ready=1;
  // instr is consumed on any ISSUE cycle with exec_done=1. Both are level
  // valid/ready pairs with no combinational path from input to output.

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_target;
  instr_t            r_instr;

  assign w_pc_inc = r_pc + ADDR_W'(PC_STEP);
  // Jump target is the low ADDR_W bits of the instruction (the result byte).
  assign w_target = ADDR_W'(r_instr);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      ST_IDLE: begin
        if (en) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ready) w_state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (exec_done) begin
          if (halt) begin
            w_state_nxt = ST_HALTED;
          end else begin
            w_pc_nxt    = (is_cond && take) ? w_target : w_pc_inc;
            w_state_nxt = en ? ST_FETCH : ST_IDLE;
          end
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (r_state == ST_FETCH && imem_ready) r_instr <= imem_data;
    end
  end

  assign imem_req    = (r_state == ST_FETCH);
  assign instr_valid = (r_state == ST_ISSUE);
  assign halted      = (r_state == ST_HALTED);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: memory/execute BFM driver, reference model of the
// program flow, and a negedge monitor popping expected fetches and instructions.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        is_cond;
  logic        take;
  logic        halt;
  logic [7:0]  pc;
  logic        halted;
  seq_state_t  dbg_state;

  pc_sequencer #(.ADDR_W(8), .PC_STEP(4), .RESET_PC(8'd0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_data  (imem_data),
    .instr      (instr),
    .instr_valid(instr_valid),
    .exec_done  (exec_done),
    .is_cond    (is_cond),
    .take       (take),
    .halt       (halt),
    .pc         (pc),
    .halted     (halted),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [31:0] mem [64];
  logic [7:0]  model_pc;
  logic        model_halted;
  logic [7:0]  exp_q [$];
  logic [31:0] exp_instr_q [$];
  int          checks;
  int          errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_ctl();
    is_cond = 1'($urandom_range(0, 1));
    take    = 1'($urandom_range(0, 1));
    halt    = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    model_pc     = 8'd0;
    model_halted = 1'b0;
    exp_q.delete();
    exp_instr_q.delete();
    en = 1'b0; imem_ready = 1'b0; imem_data = '0;
    exec_done = 1'b0; is_cond = 1'b0; take = 1'b0; halt = 1'b0;
    #1;
    check("rst_pc", pc, 8'd0);
    check("rst_addr", imem_addr, 8'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    exp_q.push_back(8'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic halted_phase();
    for (int i = 0; i < 6; i++) begin
      en         = 1'($urandom_range(0, 1));
      imem_ready = 1'($urandom_range(0, 1));
      exec_done  = 1'($urandom_range(0, 1));
      junk_ctl();
      tick();
      check("halt_req", imem_req, 1'b0);
      check("halt_flag", halted, 1'b1);
    end
    do_reset();
  endtask

  // abort: 0 none, 1 reset during fetch wait, 2 reset during issue
  task automatic run_instr(input int waits, input int delay, input logic h, input logic c,
                           input logic t, input logic en_nxt, input int abort);
    logic [31:0] w;
    if (!imem_req) begin
      check("idle_valid", instr_valid, 1'b0);
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        en = 1'b0;
        exec_done = 1'($urandom_range(0, 1));
        tick();
        check("idle_req", imem_req, 1'b0);
      end
      en = 1'b1;
      tick();
      check("fetch_after_en", imem_req, 1'b1);
    end
    w = mem[model_pc[7:2]];
    for (int i = 0; i < waits; i++) begin
      en         = 1'($urandom_range(0, 1));
      imem_ready = 1'b0;
      imem_data  = $urandom;
      exec_done  = 1'($urandom_range(0, 1));
      junk_ctl();
      tick();
      check("wait_req", imem_req, 1'b1);
      check("wait_addr", imem_addr, model_pc);
      check("wait_valid", instr_valid, 1'b0);
    end
    if (abort == 1) begin
      do_reset();
      return;
    end
    imem_ready = 1'b1;
    imem_data  = w;
    exec_done  = 1'b0;
    exp_instr_q.push_back(w);
    tick();
    imem_ready = 1'b0;
    imem_data  = $urandom;
    check("valid_rise", instr_valid, 1'b1);
    for (int i = 0; i < delay; i++) begin
      en         = 1'($urandom_range(0, 1));
      imem_ready = 1'($urandom_range(0, 1));
      junk_ctl();
      tick();
      check("valid_hold", instr_valid, 1'b1);
    end
    if (abort == 2) begin
      do_reset();
      return;
    end
    en = en_nxt; exec_done = 1'b1; halt = h; is_cond = c; take = t; imem_ready = 1'b0;
    tick();
    exec_done = 1'b0; halt = 1'b0; is_cond = 1'b0; take = 1'b0;
    if (h) begin
      model_halted = 1'b1;
    end else begin
      model_pc = (c && t) ? w[7:0] : 8'((int'(model_pc) + 4) % 256);
      exp_q.push_back(model_pc);
    end
    check("post_valid", instr_valid, 1'b0);
    check("post_req", imem_req, !h && en_nxt);
    if (h) halted_phase();
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    check("mutex", imem_req & instr_valid, 1'b0);
    check("pc", pc, model_pc);
    check("addr", imem_addr, model_pc);
    check("halted", halted, model_halted);
    if (imem_req && imem_ready) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_fetch: got addr %h expected none", imem_addr);
      end else begin
        check("fetch_addr", imem_addr, exp_q.pop_front());
      end
    end
    if (instr_valid) begin
      if (exp_instr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_issue: got instr %h expected none", instr);
      end else begin
        check("instr", instr, exp_instr_q[0]);
        if (exec_done) void'(exp_instr_q.pop_front());
      end
    end
  end

  // stimulus
  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1; en = 1'b0; imem_ready = 1'b0; imem_data = '0;
    exec_done = 1'b0; is_cond = 1'b0; take = 1'b0; halt = 1'b0;
    model_pc = 8'd0; model_halted = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    #2;
    do_reset();

    // sequential fetch 0,4,8,12
    for (int i = 0; i < 4; i++) run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    // taken jump to 0x10 (own address), then not-taken
    mem[4] = 32'h0000_0010;
    run_instr(0, 1, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    run_instr(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    // jump to 252 then wrap to 0
    mem[5] = 32'h0000_00FC;
    run_instr(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    // three wait states, then drop en at retirement
    run_instr(3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_instr(1, 2, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    // halt wins over taken jump
    run_instr(0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    // reset mid-issue and mid-fetch
    run_instr(0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    run_instr(0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    run_instr(2, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1);

    for (int n = 0; n < 160; n++) begin
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) != 0),
                ($urandom_range(0, 29) == 0) ? int'($urandom_range(1, 2)) : 0);
    end

    tick();
    check("issue_q_empty", exp_instr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
